// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer: latches edge-triggered IRQs and invalid-opcode events,
// arbitrates by fixed priority and runs the Exc/ExcAck/ERet handshake with the datapath.
module exc_irq_ctrl #(
   parameter int unsigned N_IRQ     = 4,
   parameter int unsigned ESTATUS_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_IRQ-1:0]     ExtIRQ,
   input  logic [N_IRQ-1:0]     IrqMask,
   input  logic                 NotAnInstr,
   input  logic                 ExcAck,
   input  logic                 ERet,
   output logic                 Exc,
   output logic [ESTATUS_W-1:0] EStatus,
   output logic [N_IRQ-1:0]     ExtIAck,
   output logic                 InHandler,
   output logic                 Fault
);

   localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam logic [ESTATUS_W-1:0] CAUSE_INVALID = ESTATUS_W'(4'b0010);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HANDLER = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [N_IRQ-1:0]     pending_q;
   logic [N_IRQ-1:0]     prev_q;
   logic [ESTATUS_W-1:0] cause_q;
   logic [IDX_W-1:0]     winner_q;
   logic                 irq_cause_q;
   logic                 fault_q;

   logic [N_IRQ-1:0]     rise;
   logic [N_IRQ-1:0]     eligible;
   logic                 any_eligible;
   logic [IDX_W-1:0]     pick_idx;
   logic [ESTATUS_W-1:0] pick_code;

   assign rise         = ExtIRQ & ~prev_q;
   assign eligible     = pending_q & IrqMask;
   assign any_eligible = |eligible;
   assign pick_code    = ESTATUS_W'({1'b1, 3'(pick_idx)});

   // Lowest-index enabled pending channel wins.
   always_comb begin
      pick_idx = '0;
      for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
         if (eligible[i]) pick_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (NotAnInstr || any_eligible) state_d = REQ;
         REQ:     if (ExcAck) state_d = HANDLER;
         HANDLER: if (ERet) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Invalid opcode in IDLE raises Exc in the same cycle; IRQ requests wait for REQ.
   always_comb begin
      Exc       = 1'b0;
      EStatus   = '0;
      ExtIAck   = '0;
      InHandler = 1'b0;
      Fault     = fault_q;
      case (state_q)
         IDLE: begin
            Exc     = NotAnInstr;
            EStatus = NotAnInstr ? CAUSE_INVALID : '0;
         end
         REQ: begin
            Exc     = 1'b1;
            EStatus = cause_q;
            if (ExcAck && irq_cause_q) ExtIAck = N_IRQ'(1) << winner_q;
         end
         HANDLER: begin
            EStatus   = cause_q;
            InHandler = 1'b1;
         end
         default: ;
      endcase
   end

   // A rise in the acknowledge cycle re-pends the channel (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         prev_q      <= '0;
         cause_q     <= '0;
         winner_q    <= '0;
         irq_cause_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         prev_q    <= ExtIRQ;
         pending_q <= (pending_q & ~ExtIAck) | rise;
         if (state_q == HANDLER && NotAnInstr) fault_q <= 1'b1;
         if (state_q == IDLE) begin
            if (NotAnInstr) begin
               cause_q     <= CAUSE_INVALID;
               irq_cause_q <= 1'b0;
            end else if (any_eligible) begin
               cause_q     <= pick_code;
               winner_q    <= pick_idx;
               irq_cause_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Scoreboard bench for exc_irq_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_exc_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ExtIRQ;
   logic [3:0] IrqMask;
   logic       NotAnInstr;
   logic       ExcAck;
   logic       ERet;
   logic       Exc;
   logic [3:0] EStatus;
   logic [3:0] ExtIAck;
   logic       InHandler;
   logic       Fault;

   exc_irq_ctrl #(.N_IRQ(4), .ESTATUS_W(4)) dut (
      .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .IrqMask(IrqMask),
      .NotAnInstr(NotAnInstr), .ExcAck(ExcAck), .ERet(ERet),
      .Exc(Exc), .EStatus(EStatus), .ExtIAck(ExtIAck),
      .InHandler(InHandler), .Fault(Fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       exc;
      logic [3:0] est;
      logic [3:0] iack;
      logic       inh;
      logic       flt;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   // Model: which request is outstanding, and which channels are owed service.
   bit   pend [4];
   bit   prev_lvl [4];
   int   phase;        // 0 = free, 1 = request outstanding, 2 = in handler
   int   cause;
   int   chan;
   bit   cause_is_irq;
   bit   fault_seen;
   logic [3:0] cur_irq;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0;
         prev_lvl[i] = 0;
      end
      phase = 0; cause = 0; chan = 0; cause_is_irq = 0; fault_seen = 0;
   endtask

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
   task automatic step(input logic r, input logic [3:0] irq, input logic [3:0] mask,
                       input logic nai, input logic ack, input logic eret);
      exp_t e;
      int   w;
      int   old_phase;
      @(posedge clk);
      #1;
      reset = r; ExtIRQ = irq; IrqMask = mask; NotAnInstr = nai; ExcAck = ack; ERet = eret;
      e.exc  = (phase == 1) || (phase == 0 && nai);
      e.est  = (phase == 0) ? (nai ? 4'd2 : 4'd0) : 4'(cause);
      e.iack = (phase == 1 && ack && cause_is_irq) ? 4'(1 << chan) : 4'd0;
      e.inh  = (phase == 2);
      e.flt  = fault_seen;
      sb.push_back(e);
      if (r) begin
         model_reset();
      end else begin
         old_phase = phase;
         w = -1;
         for (int i = 0; i < 4; i++)
            if (w < 0 && pend[i] && mask[i]) w = i;
         if (old_phase == 2 && nai) fault_seen = 1;
         if (old_phase == 0) begin
            if (nai) begin
               phase = 1; cause = 2; cause_is_irq = 0;
            end else if (w >= 0) begin
               phase = 1; cause = 8 + w; chan = w; cause_is_irq = 1;
            end
         end else if (old_phase == 1) begin
            if (ack) phase = 2;
         end else begin
            if (eret) phase = 0;
         end
         for (int i = 0; i < 4; i++) begin
            if (e.iack[i]) pend[i] = 0;
            if (irq[i] && !prev_lvl[i]) pend[i] = 1;
            prev_lvl[i] = irq[i];
         end
      end
   endtask

   task automatic idle(input int n, input logic [3:0] mask);
      for (int i = 0; i < n; i++) step(1'b0, cur_irq, mask, 1'b0, 1'b0, 1'b0);
   endtask

   // Wait (bounded) until a request is outstanding, acknowledge it, then return via ERET.
   task automatic serve(input logic [3:0] mask);
      for (int i = 0; i < 8 && phase != 1; i++) step(1'b0, cur_irq, mask, 1'b0, 1'b0, 1'b0);
      step(1'b0, cur_irq, mask, 1'b0, 1'b1, 1'b0);
      idle(2, mask);
      step(1'b0, cur_irq, mask, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: every cycle the DUT presents its outputs; compare to the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("Exc",       int'(Exc),       int'(e.exc));
            check("EStatus",   int'(EStatus),   int'(e.est));
            check("ExtIAck",   int'(ExtIAck),   int'(e.iack));
            check("InHandler", int'(InHandler), int'(e.inh));
            check("Fault",     int'(Fault),     int'(e.flt));
         end
      end
   end

   initial begin
      logic [3:0] m;
      reset = 1'b1; ExtIRQ = 4'hF; IrqMask = 4'h0; NotAnInstr = 1'b0; ExcAck = 1'b0; ERet = 1'b0;
      model_reset();
      cur_irq = 4'hF;

      // Reset with all levels high; after release all four channels pend.
      step(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
      idle(3, 4'h0);
      idle(3, 4'h1);
      step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      cur_irq = 4'h0;
      idle(2, 4'hF);

      // Single channel 2.
      cur_irq = 4'b0100;
      serve(4'hF);
      idle(2, 4'hF);

      // Channels 3 and 1 together: 1 first, then 3.
      cur_irq = 4'b1110;
      serve(4'hF);
      serve(4'hF);
      idle(2, 4'hF);

      // Invalid opcode beats a pending channel 0.
      cur_irq = 4'b1111;
      step(1'b0, cur_irq, 4'hF, 1'b1, 1'b0, 1'b0);
      serve(4'hF);
      serve(4'hF);
      idle(2, 4'hF);

      // Masked pending channel stays quiet until unmasked.
      cur_irq = 4'b0000;
      idle(1, 4'h0);
      cur_irq = 4'b0001;
      idle(4, 4'h0);
      serve(4'h1);

      // Rise during the acknowledge cycle re-pends the same channel.
      cur_irq = 4'b0000;
      idle(1, 4'hF);
      cur_irq = 4'b0001;
      for (int i = 0; i < 8 && phase != 1; i++) step(1'b0, cur_irq, 4'hF, 1'b0, 1'b0, 1'b0);
      cur_irq = 4'b0000;
      step(1'b0, cur_irq, 4'hF, 1'b0, 1'b0, 1'b0);
      cur_irq = 4'b0001;
      step(1'b0, cur_irq, 4'hF, 1'b0, 1'b1, 1'b0);
      step(1'b0, cur_irq, 4'hF, 1'b0, 1'b0, 1'b1);
      serve(4'hF);

      // Stray ExcAck/ERet outside their states, then NotAnInstr inside a handler.
      step(1'b0, cur_irq, 4'hF, 1'b0, 1'b1, 1'b1);
      step(1'b0, cur_irq, 4'hF, 1'b1, 1'b0, 1'b0);
      step(1'b0, cur_irq, 4'hF, 1'b0, 1'b1, 1'b0);
      step(1'b0, cur_irq, 4'hF, 1'b1, 1'b0, 1'b1);
      idle(3, 4'hF);

      // Reset while a request is outstanding.
      cur_irq = 4'b1000;
      for (int i = 0; i < 8 && phase != 1; i++) step(1'b0, cur_irq, 4'hF, 1'b0, 1'b0, 1'b0);
      step(1'b1, cur_irq, 4'hF, 1'b0, 1'b0, 1'b0);
      idle(3, 4'h0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cur_irq = cur_irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         m = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
         step(($urandom % 200) == 0, cur_irq, m, ($urandom % 12) == 0,
              ($urandom % 3) == 0, ($urandom % 4) == 0);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
